// File: rtl/seg_carry_adder.sv
// Digit-serial ripple-carry adder: one SEG_W-bit segment per clock, carry held in c_q.
// Optional subtract mode is enabled by defining SEG_CARRY_ADDER_SUB_EN.
module seg_carry_adder #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SEG_CARRY_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSEG   = WIDTH / SEG_W;
  localparam int SIDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SIDX_W-1:0] LAST_IDX = SIDX_W'(NSEG - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic [SIDX_W-1:0]   seg_idx_q;
  logic                c_q;
  logic                cout_q, ovf_q, out_valid_q;

  logic [SEG_W-1:0]    a_seg [NSEG];
  logic [SEG_W-1:0]    b_seg [NSEG];
  logic [SEG_W-1:0]    a_cur, b_cur, seg_sum;
  logic [SEG_W:0]      carry;
  logic                last_seg;
  logic                accept;
  logic [WIDTH-1:0]    b_eff;
  logic                c_eff;

  // In subtract mode the operand is stored pre-inverted so RUN only ever adds.
`ifdef SEG_CARRY_ADDER_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;
`else
  assign b_eff = b;
  assign c_eff = cin;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      assign a_seg[gi] = a_q[gi*SEG_W +: SEG_W];
      assign b_seg[gi] = b_q[gi*SEG_W +: SEG_W];
    end
  endgenerate

  assign a_cur    = a_seg[seg_idx_q];
  assign b_cur    = b_seg[seg_idx_q];
  assign carry[0] = c_q;

  generate
    for (gi = 0; gi < SEG_W; gi++) begin : g_ripple
      assign seg_sum[gi]  = a_cur[gi] ^ b_cur[gi] ^ carry[gi];
      assign carry[gi+1]  = (a_cur[gi] & b_cur[gi]) | (carry[gi] & (a_cur[gi] ^ b_cur[gi]));
    end
  endgenerate

  assign last_seg = (seg_idx_q == LAST_IDX);
  assign accept   = (state_q == IDLE) && in_valid && !rst;

  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < NSEG; i++) begin
      if (seg_idx_q == SIDX_W'(i)) begin
        sum_d[i*SEG_W +: SEG_W] = seg_sum;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_seg)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    busy      = (state_q == RUN) || (state_q == DONE);
    out_valid = out_valid_q;
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      seg_idx_q   <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q       <= a;
            b_q       <= b_eff;
            c_q       <= c_eff;
            seg_idx_q <= '0;
            sum_q     <= '0;
          end
        end
        RUN: begin
          sum_q <= sum_d;
          c_q   <= carry[SEG_W];
          if (last_seg) begin
            // carry[SEG_W-1] of the top segment is the carry into bit WIDTH-1
            seg_idx_q   <= '0;
            cout_q      <= carry[SEG_W];
            ovf_q       <= carry[SEG_W] ^ carry[SEG_W-1];
            out_valid_q <= 1'b1;
          end else begin
            seg_idx_q <= seg_idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_carry_adder.sv
// Directed bench for seg_carry_adder (WIDTH=16, SEG_W=4) with an expected-result queue.
module tb_seg_carry_adder;

  localparam int WIDTH = 16;
  localparam int SEG_W = 4;
  localparam int NSEG  = WIDTH / SEG_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, busy;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
  } exp_t;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  always #5 clk = ~clk;

  seg_carry_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEG_CARRY_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer add, carry into MSB taken from the low WIDTH-1 bits.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic ci, input logic sv);
    exp_t e;
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] low;
    logic [WIDTH-1:0] bb;
    logic             cc;
    bb   = sv ? ~bv : bv;
    cc   = sv ? 1'b1 : ci;
    full = {1'b0, av} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
    low  = {1'b0, av[WIDTH-2:0]} + {1'b0, bb[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cc};
    e.s  = full[WIDTH-1:0];
    e.c  = full[WIDTH];
    e.o  = low[WIDTH-1] ^ full[WIDTH];
    return e;
  endfunction

  // Accepts one operation, checks latency, then (after optional backpressure) the result.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic ci, input logic sv, input int hold);
    int   waited;
    exp_t e, got;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_ready_to_accept"}, {31'd0, in_ready}, 32'd1);
    a = av; b = bv; cin = ci; sub = sv;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back(model(av, bv, ci, sv));
    tick();
    in_valid = 1'b0;
    for (int n = 1; n < NSEG; n++) begin
      tick();
      check({tag, "_no_early_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_in_ready_low_run"}, {31'd0, in_ready}, 32'd0);
    end
    tick();
    check({tag, "_out_valid_at_nseg"}, {31'd0, out_valid}, 32'd1);
    e = exp_q.pop_front();
    got = '{s: sum, c: cout, o: ovf};
    check({tag, "_sum"},  {16'd0, sum}, {16'd0, e.s});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, e.c});
    check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, e.o});
    check({tag, "_in_ready_low_done"}, {31'd0, in_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      a = ~av; b = ~bv; in_valid = h[0];
      tick();
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_stable"}, {15'd0, sum, cout, ovf}, {15'd0, got.s, got.c, got.o});
      check({tag, "_hold_no_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check({tag, "_valid_dropped"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_back_idle"}, {30'd0, in_ready, busy}, 32'd2);
    $display("txn %s a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d", tag, av, bv, ci, sv,
             got.s, got.c, got.o);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("reset_outputs", {13'd0, sum, cout, ovf, out_valid, busy}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    run_op("basic",   16'h1234, 16'h1111, 1'b0, 1'b0, 0);
    run_op("carry",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 0);
    run_op("cin",     16'hABCD, 16'h5432, 1'b1, 1'b0, 0);
    run_op("backpr",  16'h0F0F, 16'h0F0F, 1'b1, 1'b0, 5);

    // Reset while seg_idx == 2: the operation must vanish without a result.
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_outputs", {13'd0, sum, cout, ovf, out_valid, busy}, 32'd0);
    for (int n = 0; n < NSEG + 2; n++) begin
      tick();
      check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0);

`ifdef SEG_CARRY_ADDER_SUB_EN
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_carry_adder.md
Name: seg_carry_adder

Overview:
- Parametrised, digit-serial ripple-carry adder with a valid/ready handshake on both sides.
- Adds two WIDTH-bit operands plus carry-in, one SEG_W-bit segment per clock, with the carry held in a register between segments.
- Trades latency for a short carry chain: only an SEG_W-bit ripple per cycle.
- Feeds accumulator and datapath blocks that need wide adds at high clock rates.

Parameters:
- WIDTH, 16, operand and sum width in bits.
- SEG_W, 4, bits added per cycle. Must divide WIDTH. NSEG = WIDTH/SEG_W, and NSEG >= 1.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  registered sum.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Segment index seg_idx counts 0..NSEG-1. Carry register is c_q.
- Reset (rst high at an edge): state goes to IDLE; sum=0, cout=0, ovf=0, out_valid=0, seg_idx=0, c_q=0.
- in_ready = (state==IDLE) && !rst. It is combinational.
- IDLE:
  - On in_valid && in_ready: latch a, b, cin into operand registers; c_q <= cin; seg_idx <= 0; sum <= 0; go to RUN.
  - in_valid while not ready is ignored. The producer must hold the operands.
- RUN, each cycle:
  - Segment i = seg_idx computes a[i*SEG_W +: SEG_W] + b[same] + c_q as an SEG_W-bit ripple.
  - Result is written to sum[i*SEG_W +: SEG_W]; c_q <= carry out of the segment; seg_idx increments.
  - When i == NSEG-1:
    - cout <= segment carry out.
    - ovf <= (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
    - Go to DONE with out_valid=1.
- Latency: the operand accept edge is edge k. out_valid is first high after edge k+NSEG.
- DONE:
  - sum, cout and ovf stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid <= 0, go to IDLE. New operands can be accepted on the following cycle.
  - Minimum initiation interval is NSEG+2 cycles.
- In RUN and DONE, in_ready=0 and in_valid has no effect.
- Intermediate sum contents during RUN are not architecturally defined. Checkers sample only when out_valid is high.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the unsigned carry. ovf is meaningful for signed interpretation.
- NSEG == 1: RUN lasts exactly one cycle. The result equals a full WIDTH-bit ripple add.
- Reset mid-operation (RUN or DONE): the operation is discarded, no out_valid pulse is produced, and all outputs return to reset values on that edge.
- Simultaneous rst and a handshake: rst wins.

Optional Feature:
- Macro SEG_CARRY_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands.
  - sub=1: computes a + ~b + 1; cin is ignored. cout=1 means no borrow. ovf uses the same MSB carry rule.
  - sub=0: identical to add mode.
- Undefined: the port is absent and the block only adds.

Test Plan:
- WIDTH=16, SEG_W=4: a=0x1234, b=0x1111, cin=0 → out_valid exactly 4 cycles after the accept edge; sum=0x2345, cout=0, ovf=0; in_ready=0 throughout RUN/DONE.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. The carry crosses all 4 segment boundaries.
- Signed overflow:
  - a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
  - a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid and pulse in_valid meanwhile → sum/cout/ovf unchanged, no new accept. Raise out_ready → IDLE next cycle, in_ready=1.
- Assert rst for one cycle while seg_idx=2 → outputs 0, out_valid never pulses. Then a=0x0F0F, b=0x00F1, cin=0 → sum=0x1000, cout=0.
- With SEG_CARRY_ADDER_SUB_EN: a=0x0005, b=0x0007, sub=1, cin=1 → sum=0xFFFE, cout=0, ovf=0. Also a=0x0007, b=0x0005, sub=1 → sum=0x0002, cout=1.
